// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
//   - opcode and funct field constants for the supported instruction subset
//   - 4-bit ALU control codes, shared with the ALU itself
//   - ALU operation class (aluop) codes used between the FSM and alu_decoder
//   - controller state encodings (also visible on the debug state port)
package mips_pkg;

  // Opcode field, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Funct field, instr[5:0], meaningful for R-type only
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Operation class requested by the FSM; FUNCT defers to the funct field
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Controller states. Codes 12-15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// ALU control decoder.
//   aluop       in  2  operation class from the main FSM (add / sub / by funct)
//   funct       in  6  instr[5:0]
//   alucontrol  out 4  code for the ALU
//   funct_legal out 1  funct is one of the supported R-type operations,
//                      independent of aluop so DECODE can reject bad R-types
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] alucontrol,
  output logic       funct_legal
);

  logic [3:0] funct_alu;

  always_comb begin
    funct_alu   = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (aluop)
      ALUOP_ADD:   alucontrol = ALU_ADD;
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: alucontrol = funct_alu;
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style main control FSM for the multicycle MIPS datapath.
// Sequences fetch / decode / execute / memory / writeback over a shared
// instruction+data memory with a ready handshake.
//   clk, reset   clock and synchronous active-high reset
//   opcode       instr[31:26] from the instruction register
//   funct        instr[5:0] from the instruction register
//   zero         ALU zero flag, used for beq
//   mem_ready    memory completes the current access this cycle
//   alucontrol   ALU operation code
//   alusrca      0=PC, 1=regA
//   alusrcb      00=regB, 01=4, 10=signimm, 11=signimm<<2
//   pcsrc        00=ALU result, 01=ALUOut, 10=jump address
//   pcen         PC load enable
//   iord         0=PC addresses memory, 1=ALUOut addresses memory
//   irwrite      instruction register load
//   memwrite     memory write strobe
//   regwrite     register file write
//   regdst       0=rt, 1=rd
//   memtoreg     0=ALUOut, 1=memory data
//   illegal_op   one-cycle pulse on an undecodable instruction
//   state        current state, for debug
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic [FNW-1:0] funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic [3:0]     alucontrol,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic           pcen,
  output logic           iord,
  output logic           irwrite,
  output logic           memwrite,
  output logic           regwrite,
  output logic           regdst,
  output logic           memtoreg,
  output logic           illegal_op,
  output logic [3:0]     state
);

  state_t     state_reg;
  state_t     state_next;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       branch;
  logic       funct_legal;

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct       (funct),
    .alucontrol  (alucontrol),
    .funct_legal (funct_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    aluop      = ALUOP_ADD;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    illegal_op = 1'b0;

    case (state_reg)
      S_FETCH: begin
        // PC+4 computed every cycle; only committed once the read lands
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite    = 1'b1;
          pcwrite    = 1'b1;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target is precomputed into ALUOut while decoding
        alusrcb = 2'b11;
        case (opcode)
          OP_RTYPE: begin
            if (funct_legal) begin
              state_next = S_RTYPEEX;
            end else begin
              illegal_op = 1'b1;
              state_next = S_FETCH;
            end
          end
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
          default: begin
            // Unknown opcode is dropped as a NOP
            illegal_op = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) begin
          state_next = S_MEMWB;
        end
      end

      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end

      S_MEMWR: begin
        // Strobe held until the memory accepts; leaving on mem_ready
        // guarantees the store is accepted exactly once
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          state_next = S_FETCH;
        end
      end

      S_RTYPEEX: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_FUNCT;
        state_next = S_RTYPEWB;
      end

      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end

      S_BEQEX: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        state_next = S_FETCH;
      end

      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = S_ADDIWB;
      end

      S_ADDIWB: begin
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end

      S_JEX: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        state_next = S_FETCH;
      end

      default: state_next = S_FETCH;
    endcase

    // Reset overrides everything combinationally so an in-flight store or
    // register write is killed in the very cycle reset is seen.
    if (reset) begin
      state_next = S_FETCH;
      aluop      = ALUOP_ADD;
      alusrca    = 1'b0;
      alusrcb    = 2'b01;
      pcsrc      = 2'b00;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = state_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] state;
    logic [3:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       illegal_op;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] alucontrol;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, illegal_op;
  logic [3:0] state;

  mips_multicycle_ctrl #(.OPW(6), .FNW(6)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alucontrol(alucontrol), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .iord(iord),
    .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   zero_force = -1;
  int   cyc = 0;

  // Step identifiers follow the documented state numbering.
  localparam int K_FETCH = 0, K_DECODE = 1, K_MEMADR = 2, K_MEMRD = 3,
                 K_MEMWB = 4, K_MEMWR = 5, K_REX = 6, K_RWB = 7,
                 K_BEQ = 8, K_AEX = 9, K_AWB = 10, K_J = 11;

  // ---------------- reference model ----------------
  function automatic bit funct_ok(logic [5:0] fn);
    return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
           fn == 6'b100101 || fn == 6'b101010;
  endfunction

  function automatic logic [3:0] rtype_alu(logic [5:0] fn);
    case (fn)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic bit op_known(logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  function automatic bit decode_illegal(logic [5:0] op, logic [5:0] fn);
    return !op_known(op) || (op == 6'b000000 && !funct_ok(fn));
  endfunction

  // Ordered list of steps an instruction walks through.
  task automatic build_plan(input logic [5:0] op, input logic [5:0] fn, output int plan[$]);
    plan = {};
    plan.push_back(K_FETCH);
    plan.push_back(K_DECODE);
    if (decode_illegal(op, fn)) return;
    case (op)
      6'b100011: plan = {plan, K_MEMADR, K_MEMRD, K_MEMWB};
      6'b101011: plan = {plan, K_MEMADR, K_MEMWR};
      6'b000100: plan.push_back(K_BEQ);
      6'b001000: plan = {plan, K_AEX, K_AWB};
      6'b000010: plan.push_back(K_J);
      default:   plan = {plan, K_REX, K_RWB};
    endcase
  endtask

  function automatic obs_t expect_cycle(int kind, logic [5:0] op, logic [5:0] fn,
                                        bit z, bit mr, bit rst);
    obs_t e;
    e = '0;
    e.state      = kind[3:0];
    e.alucontrol = 4'b0010;
    if (rst) begin
      e.alusrcb = 2'b01;
      return e;
    end
    case (kind)
      K_FETCH:  begin e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
      K_DECODE: begin e.alusrcb = 2'b11; e.illegal_op = decode_illegal(op, fn); end
      K_MEMADR: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      K_MEMRD:  e.iord = 1'b1;
      K_MEMWB:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      K_MEMWR:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
      K_REX:    begin e.alusrca = 1'b1; e.alucontrol = rtype_alu(fn); end
      K_RWB:    begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      K_BEQ:    begin e.alusrca = 1'b1; e.alucontrol = 4'b0110; e.pcsrc = 2'b01; e.pcen = z; end
      K_AEX:    begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      K_AWB:    e.regwrite = 1'b1;
      K_J:      begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      default:  ;
    endcase
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    obs_t g, e;
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {state, alucontrol, alusrca, alusrcb, pcsrc, pcen, iord, irwrite,
           memwrite, regwrite, regdst, memtoreg, illegal_op};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle_outputs cyc=%0d state got=%0d exp=%0d vec got=%h exp=%h",
                 cyc, g.state, e.state, g, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cycle(int kind, bit mr, bit z, bit rst);
    mem_ready = mr;
    zero      = z;
    reset     = rst;
    exp_q.push_back(expect_cycle(kind, opcode, funct, z, mr, rst));
    tick();
  endtask

  // stall < 0 means random mem_ready in waiting steps; abort_kind selects a
  // waiting step in which reset is raised on its second cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fstall, input int mstall, input int abort_kind);
    int  plan[$];
    int  cycles;
    bit  aborted;
    opcode  = op;
    funct   = fn;
    cycles  = 0;
    aborted = 1'b0;
    build_plan(op, fn, plan);
    foreach (plan[i]) begin
      int kind;
      int waited;
      int stall;
      bit done;
      bit w;
      if (aborted) break;
      kind   = plan[i];
      waited = 0;
      done   = 1'b0;
      w      = (kind == K_FETCH || kind == K_MEMRD || kind == K_MEMWR);
      stall  = (kind == K_FETCH) ? fstall : mstall;
      while (!done) begin
        bit mr;
        bit z;
        if (w) mr = (stall < 0) ? ($urandom_range(0, 2) != 0) : (waited >= stall);
        else   mr = $urandom_range(0, 1) != 0;
        z = (zero_force < 0) ? ($urandom_range(0, 1) != 0) : zero_force[0];
        if (kind == abort_kind && waited == 1) begin
          drive_cycle(kind, mr, z, 1'b1);
          reset   = 1'b0;
          aborted = 1'b1;
          done    = 1'b1;
        end else begin
          drive_cycle(kind, mr, z, 1'b0);
          if (!w || mr) done = 1'b1;
          else waited++;
        end
        cycles++;
      end
    end
    $display("instr op=%b fn=%b cycles=%0d%s", op, fn, cycles, aborted ? " aborted" : "");
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    reset = 1'b1;
    tick();
    drive_cycle(K_FETCH, 1'b1, 1'b0, 1'b1);
    drive_cycle(K_FETCH, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;

    // Directed scenarios
    run_instr(6'b100011, 6'b000000, 0, 0, -1);   // lw, no stalls
    run_instr(6'b000000, 6'b101010, 3, 0, -1);   // slt, fetch stalled 3
    run_instr(6'b101011, 6'b000000, 0, 2, -1);   // sw, write stalled 2
    zero_force = 1;
    run_instr(6'b000100, 6'b000000, 0, 0, -1);   // beq taken
    zero_force = 0;
    run_instr(6'b000100, 6'b000000, 0, 0, -1);   // beq not taken
    zero_force = -1;
    run_instr(6'b000000, 6'b000111, 0, 0, -1);   // illegal funct
    run_instr(6'b101011, 6'b000000, 0, 4, K_MEMWR); // reset during store
    run_instr(6'b111111, 6'b000000, 0, 0, -1);   // illegal opcode
    run_instr(6'b000010, 6'b000000, 0, 0, -1);   // j
    run_instr(6'b001000, 6'b000000, 0, 0, -1);   // addi
    run_instr(6'b000000, 6'b100000, 0, 0, -1);
    run_instr(6'b000000, 6'b100010, 0, 0, -1);
    run_instr(6'b000000, 6'b100100, 0, 0, -1);
    run_instr(6'b000000, 6'b100101, 0, 0, -1);
    run_instr(6'b100011, 6'b000000, 1, 2, K_MEMRD); // reset during load

    // Randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        default: op = 6'($urandom_range(0, 63));
      endcase
      case ($urandom_range(0, 5))
        0: fn = 6'b100000;
        1: fn = 6'b100010;
        2: fn = 6'b100100;
        3: fn = 6'b100101;
        4: fn = 6'b101010;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, fn, -1, -1, ($urandom_range(0, 19) == 0) ? K_MEMWR : -1);
    end

    // Let the monitor drain the remaining expectations (bounded).
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style main control FSM for the multicycle MIPS datapath.
- It is the initiator side of the ALU interface: it drives the 4-bit alucontrol code and the operand-select muxes, and it consumes the ALU zero flag for branches.
- It sequences fetch, decode, execute, memory and writeback over a shared instruction/data memory, which has a ready handshake.

Parameters:
- OPW, 6, opcode field width
- FNW, 6, funct field width

Ports:
- clk  in  1  single system clock
- reset  in  1  synchronous, active-high; sampled on rising clk
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag (aluout==0)
- mem_ready  in  1  memory completes the current read/write this cycle
- alucontrol  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
- alusrca  out  1  0=PC, 1=regA
- alusrcb  out  2  00=regB, 01=const 4, 10=signimm, 11=signimm<<2
- pcsrc  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump address
- pcen  out  1  PC load enable = pcwrite | (branch & zero)
- iord  out  1  0=PC addresses memory, 1=ALUOut addresses memory
- irwrite  out  1  instruction register load
- memwrite  out  1  memory write strobe
- regwrite  out  1  register file write
- regdst  out  1  0=rt, 1=rd
- memtoreg  out  1  0=ALUOut, 1=memory data
- illegal_op  out  1  one-cycle pulse on an undecodable instruction
- state  out  4  current state, for debug/verification

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12-15 are unreachable; if entered, go to FETCH.
- Reset: state<=FETCH. While reset=1, all write enables (pcen, irwrite, memwrite, regwrite) and illegal_op are forced 0. The remaining outputs take their FETCH values.
- Reset mid-operation (e.g. in MEMWR) aborts the operation; memwrite drops in the same cycle.
- Unlisted outputs are 0 in each state. alucontrol defaults to 0010.
- FETCH: iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
  - Holds while mem_ready=0.
  - When mem_ready=1: irwrite=1, pcwrite=1 (PC+4), next DECODE.
- DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). Next state by opcode:
  - 000000 -> RTYPEEX; illegal funct -> FETCH with illegal_op=1
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000100 (beq) -> BEQEX
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JEX
  - any other opcode -> FETCH with illegal_op=1 (executed as a NOP)
- MEMADR: alusrca=1, alusrcb=10, add. Next MEMRD if opcode=lw, else MEMWR.
- MEMRD: iord=1. Holds until mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next FETCH.
- MEMWR: iord=1, memwrite=1 held every cycle until mem_ready=1, then FETCH. The write is counted exactly once.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct:
  - 100000 -> 0010 (add)
  - 100010 -> 0110 (sub)
  - 100100 -> 0000 (and)
  - 100101 -> 0001 (or)
  - 101010 -> 0111 (slt)
  - Next RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next FETCH.
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1. pcen=zero, combinational in this cycle. Next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Next ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next FETCH.
- JEX: pcsrc=10, pcwrite=1. Next FETCH.
- Latency with mem_ready tied 1 (cycles):
  - beq, j: 3
  - R-type, addi: 4
  - sw: 4
  - lw: 5
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- Outputs are combinational from state (plus funct, zero, mem_ready). State is the only register.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct constants
  - ALU control codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT), shared with the ALU
  - state encodings
- Sub-module alu_decoder: combinational {aluop[1:0], funct} -> alucontrol, plus a funct_legal flag.

Test Plan:
- Reset then release, mem_ready=1, opcode=100011: state sequence 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4.
- FETCH with mem_ready low for 3 cycles: irwrite/pcen stay 0 for 3 cycles, then pulse together on cycle 4.
- sw with mem_ready low for 2 cycles in MEMWR: memwrite=1 for 3 consecutive cycles, then FETCH.
- beq: zero=1 in BEQEX -> pcen=1, pcsrc=01, alucontrol=0110. Repeat with zero=0 -> pcen=0.
- R-type funct=101010 -> alucontrol=0111 in RTYPEEX, regdst=1 in RTYPEWB. funct=000111 -> illegal_op pulse in DECODE, next FETCH, no regwrite.
- Assert reset during MEMWR: memwrite drops the same cycle, state=FETCH next. opcode=111111 -> illegal_op=1, no write enables.
